// File: rtl/reg_write_sched.sv
// Round-robin write scheduler: serialises each accepted word LSB byte first onto a
// shared byte bus and strobes the active-low enable of the target DFFE byte chip.
module reg_write_sched #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_WORDS  = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 3,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int WORD_W    = 8 * WORD_BYTES,
    localparam int CE_W      = NUM_WORDS * WORD_BYTES
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [7:0]                bus_d,
    output logic [CE_W-1:0]           ce_n,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      addr_err
);
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [7:0]        bus_d_q, bus_d_d;
    logic [CE_W-1:0]   ce_n_q, ce_n_d;
    logic              busy_q, busy_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              addr_err_q, addr_err_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_data;
    logic [7:0]        next_byte;

    // An out-of-range address decodes to no enable at all.
    function automatic logic [CE_W-1:0] ce_decode(input logic [ADDR_W-1:0] addr,
                                                  input logic [CNT_W-1:0]  idx);
        ce_decode = '1;
        for (int w = 0; w < NUM_WORDS; w++)
            for (int b = 0; b < WORD_BYTES; b++)
                if (addr == ADDR_W'(w) && idx == CNT_W'(b))
                    ce_decode[w*WORD_BYTES + b] = 1'b0;
    endfunction

    // First valid requester at or above ptr, else the lowest valid one (wrap).
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int r = 0; r < NUM_REQ; r++)
            if (!gnt_found && req_valid[r] && ID_W'(r) >= ptr_q) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(r);
            end
        for (int r = 0; r < NUM_REQ; r++)
            if (!gnt_found && req_valid[r]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(r);
            end
        sel_addr = '0;
        sel_data = '0;
        for (int r = 0; r < NUM_REQ; r++)
            if (gnt_idx == ID_W'(r)) begin
                sel_addr = req_addr[r*ADDR_W +: ADDR_W];
                sel_data = req_data[r*WORD_W +: WORD_W];
            end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        bus_d_d    = bus_d_q;
        ce_n_d     = '1;
        busy_d     = 1'b0;
        grant_id_d = grant_id_q;
        addr_err_d = 1'b0;
        req_ready  = '0;
        next_byte  = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt_found && !RST) begin
                    req_ready[gnt_idx] = 1'b1;
                    addr_d     = sel_addr;
                    data_d     = sel_data;
                    grant_id_d = gnt_idx;
                    ptr_d      = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d      = '0;
                    state_d    = WRITE;
                    busy_d     = 1'b1;
                    bus_d_d    = sel_data[7:0];
                    ce_n_d     = ce_decode(sel_addr, '0);
                    addr_err_d = (int'(sel_addr) >= NUM_WORDS);
                end
            end
            WRITE: begin
                if (cnt_q == CNT_W'(WORD_BYTES-1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    for (int b = 0; b < WORD_BYTES; b++)
                        if (cnt_d == CNT_W'(b))
                            next_byte = data_q[8*b +: 8];
                    busy_d  = 1'b1;
                    bus_d_d = next_byte;
                    ce_n_d  = ce_decode(addr_q, cnt_d);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            bus_d_q    <= '0;
            ce_n_q     <= '1;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            bus_d_q    <= bus_d_d;
            ce_n_q     <= ce_n_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            addr_err_q <= addr_err_d;
        end
    end

    // NOTE: the word holding registers are only read in WRITE after being loaded, so they carry no reset.
    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign bus_d    = bus_d_q;
    assign ce_n     = ce_n_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_write_sched.sv
// Directed bench for reg_write_sched with a six-word bank so address 7 is out of range;
// a behavioural chip array captures bus_d wherever ce_n is low.
module tb_reg_write_sched;
    localparam int NUM_REQ    = 4;
    localparam int NUM_WORDS  = 6;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 3;
    localparam int CE_W       = NUM_WORDS * WORD_BYTES;
    localparam logic [CE_W-1:0] CE_IDLE = '1;

    localparam int          RR_ORDER [5] = '{0, 1, 2, 3, 0};
    localparam int          RR_WORD  [4] = '{0, 1, 3, 4};
    localparam logic [31:0] RR_DATA  [4] = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
    localparam logic [7:0]  SW_BYTES [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    localparam logic [7:0]  BA_BYTES [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  bus_d;
    logic [CE_W-1:0] ce_n;
    logic        busy;
    logic [1:0]  grant_id;
    logic        addr_err;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] chip_mem [CE_W] = '{default: 8'h00};

    always #5 clk = ~clk;

    reg_write_sched #(
        .NUM_REQ(NUM_REQ), .NUM_WORDS(NUM_WORDS), .WORD_BYTES(WORD_BYTES), .ADDR_W(ADDR_W)
    ) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .bus_d(bus_d), .ce_n(ce_n),
        .busy(busy), .grant_id(grant_id), .addr_err(addr_err)
    );

    always @(posedge clk)
        for (int i = 0; i < CE_W; i++)
            if (ce_n[i] === 1'b0) chip_mem[i] <= bus_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_addr[i*3 +: 3]    = a;
        req_data[i*32 +: 32]  = d;
    endtask

    function automatic logic [CE_W-1:0] ce_low(input int n);
        logic [CE_W-1:0] m;
        m    = '1;
        m[n] = 1'b0;
        return m;
    endfunction

    function automatic logic [31:0] word_of(input int w);
        return {chip_mem[w*4+3], chip_mem[w*4+2], chip_mem[w*4+1], chip_mem[w*4]};
    endfunction

    initial begin
        int g;
        logic [31:0] d;

        rst = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset with random requests pending.
        for (int c = 0; c < 2; c++) begin
            tick();
            req_valid = 4'($urandom);
            req_addr  = 12'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            settle();
            check($sformatf("rst%0d_ready", c), req_ready, 0);
            check($sformatf("rst%0d_ce_n", c), ce_n, CE_IDLE);
            check($sformatf("rst%0d_busy", c), busy, 0);
        end
        check("rst_bus_d", bus_d, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_addr_err", addr_err, 0);
        req_valid = '0;
        rst = 1'b0;

        // Round-robin with all four requesters valid continuously.
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(RR_WORD[i]), RR_DATA[i]);
        for (int j = 0; j < 5; j++) begin
            g = RR_ORDER[j];
            d = RR_DATA[g];
            settle();
            check($sformatf("rr%0d_ready", j), req_ready, 32'(1) << g);
            check($sformatf("rr%0d_idle_ce", j), ce_n, CE_IDLE);
            for (int k = 0; k < 4; k++) begin
                tick();
                if (j == 4 && k == 3) req_valid = '0;
                settle();
                check($sformatf("rr%0d_ce%0d", j, k), ce_n, ce_low(RR_WORD[g]*4 + k));
                check($sformatf("rr%0d_bus%0d", j, k), bus_d, d[8*k +: 8]);
                check($sformatf("rr%0d_gid%0d", j, k), grant_id, g);
                check($sformatf("rr%0d_nordy%0d", j, k), req_ready, 0);
                check($sformatf("rr%0d_busy%0d", j, k), busy, 1);
            end
            tick();
        end
        settle();
        check("rr_end_busy", busy, 0);
        check("rr_end_ce", ce_n, CE_IDLE);

        // Single write: req0 -> word 2.
        set_req(0, 1'b1, 3'd2, 32'hA1B2C3D4);
        settle();
        check("sw_ready", req_ready, 4'b0001);
        check("sw_busy_t", busy, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) req_valid = '0;
            settle();
            check($sformatf("sw_ce%0d", k), ce_n, ce_low(8 + k));
            check($sformatf("sw_bus%0d", k), bus_d, SW_BYTES[k]);
            check($sformatf("sw_err%0d", k), addr_err, 0);
        end
        tick();
        settle();
        check("sw_end_ce", ce_n, CE_IDLE);
        check("sw_end_busy", busy, 0);
        check("sw_bus_hold", bus_d, 8'hA1);
        check("mem_w2", word_of(2), 32'hA1B2C3D4);
        check("mem_w0", word_of(0), 32'h03020100);
        check("mem_w1", word_of(1), 32'h13121110);
        check("mem_w3", word_of(3), 32'h23222120);
        check("mem_w4", word_of(4), 32'h33323130);
        check("mem_w5", word_of(5), 32'h00000000);

        // Bad address: req1 -> word 7 in a six-word bank.
        set_req(1, 1'b1, 3'd7, 32'hDEADBEEF);
        settle();
        check("ba_ready", req_ready, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) req_valid = '0;
            settle();
            check($sformatf("ba_ce%0d", k), ce_n, CE_IDLE);
            check($sformatf("ba_err%0d", k), addr_err, (k == 0) ? 1 : 0);
            check($sformatf("ba_bus%0d", k), bus_d, BA_BYTES[k]);
            check($sformatf("ba_busy%0d", k), busy, 1);
            check($sformatf("ba_gid%0d", k), grant_id, 1);
        end
        tick();
        settle();
        check("ba_end_busy", busy, 0);
        check("ba_end_err", addr_err, 0);

        // Withdrawal: req2 raised during req0's write, then dropped before any grant.
        set_req(0, 1'b1, 3'd1, 32'h44556677);
        settle();
        check("wd_ready0", req_ready, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                req_valid[0] = 1'b0;
                set_req(2, 1'b1, 3'd5, 32'h99999999);
            end
            if (k == 2) req_valid[2] = 1'b0;
            if (k == 3) begin
                set_req(0, 1'b1, 3'd0, 32'h12345678);
                set_req(3, 1'b1, 3'd5, 32'h5A6B7C8D);
            end
            settle();
            check($sformatf("wd_nordy%0d", k), req_ready, 0);
            check($sformatf("wd_ce%0d", k), ce_n, ce_low(4 + k));
            check($sformatf("wd_gid%0d", k), grant_id, 0);
        end
        tick();
        settle();
        check("wd_next_grant", req_ready, 4'b1000);

        // Reset mid-write: req3 -> word 5, RST in the second byte cycle.
        tick();
        req_valid = '0;
        settle();
        check("rm_ce0", ce_n, ce_low(20));
        check("rm_bus0", bus_d, 8'h8D);
        check("rm_gid", grant_id, 3);
        tick();
        rst = 1'b1;
        settle();
        check("rm_ce1", ce_n, ce_low(21));
        check("rm_bus1", bus_d, 8'h7C);
        tick();
        rst = 1'b0;
        settle();
        check("rm_ce_rst", ce_n, CE_IDLE);
        check("rm_busy_rst", busy, 0);
        check("rm_bus_rst", bus_d, 0);
        check("rm_gid_rst", grant_id, 0);
        check("rm_err_rst", addr_err, 0);
        check("rm_ready_rst", req_ready, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            settle();
            check($sformatf("rm_after_ce%0d", c), ce_n, CE_IDLE);
            check($sformatf("rm_after_busy%0d", c), busy, 0);
        end
        check("mem_w5_partial", word_of(5), 32'h00007C8D);
        check("mem_w1_wd", word_of(1), 32'h44556677);

        // Pointer is back at requester 0 after reset.
        set_req(1, 1'b1, 3'd0, 32'h0);
        set_req(0, 1'b1, 3'd0, 32'h0);
        settle();
        check("rm_ptr_reset", req_ready, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
